audio_in_detector: RTL
======================

AUDIO_IN_DETECTOR -- requirements
Module: audio_in_detector

Interface
REQ-001 SHALL have parameter THRESHOLD, default 16'h0800, envelope level that triggers a detection.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 25_000_000, minimum number of clocks between detections (0.5 s at 50 MHz).
REQ-003 SHALL have parameter DECAY_SHIFT, default 4, envelope decay shift applied once per sample.
REQ-004 SHALL have port CLOCK_50, input, 1 bit, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit; while low, no samples are read and no detections are issued.
REQ-007 SHALL have port audio_in_available, input, 1 bit; the Audio_Controller has an input sample pair ready.
REQ-008 SHALL have port left_channel_audio_in, input, 32 bits, signed left sample.
REQ-009 SHALL have port right_channel_audio_in, input, 32 bits, signed right sample.
REQ-010 SHALL have port read_audio_in, output, 1 bit, single-cycle pop strobe to the Audio_Controller.
REQ-011 SHALL have port clap_detected, output, 1 bit, single-cycle pulse marking a detected loud event (jump trigger).
REQ-012 SHALL have port level, output, 16 bits, current envelope value.

Function
REQ-013 SHALL implement FSM with states IDLE, READ, MAG, ENV, CMP; IDLE->READ when audio_in_available && enable; READ->MAG->ENV->CMP->IDLE unconditionally.
REQ-014 SHALL assert read_audio_in only in READ, for exactly one cycle per sample, and latch both channel inputs at the end of that cycle.
REQ-015 SHALL NOT issue a second read_audio_in until the FSM has returned to IDLE; audio_in_available held high yields one read per 5 clocks.
REQ-016 SHALL, in MAG, form per-channel magnitude as abs(sample) saturated to 32'h7FFF_FFFF, then take bits [30:15] as a 16-bit magnitude.
REQ-017 SHALL, in ENV, update env <= max(mag, env - (env >> DECAY_SHIFT)); env never wraps below 0 or above 16'hFFFF.
REQ-018 SHALL drive level from env continuously; level changes only on the ENV-to-CMP transition.
REQ-019 SHALL, in CMP, pulse clap_detected high on the next clock when armed && holdoff counter == 0 && env >= THRESHOLD.
REQ-020 SHALL clear armed and load the holdoff counter with HOLDOFF_CYCLES-1 on the same clock that clap_detected is pulsed.
REQ-021 SHALL decrement the holdoff counter every clock while it is nonzero, independent of FSM state, and stop at 0.
REQ-022 SHALL set armed in CMP when env < (THRESHOLD >> 1) and the holdoff counter == 0 (hysteresis re-arm).
REQ-023 SHALL, when enable falls mid-sequence, complete the current READ..CMP sequence but suppress clap_detected; it then idles.
REQ-024 SHALL, when a detection condition and the re-arm condition coincide, give detection priority.
REQ-025 SHALL use latency of 4 clocks from the read_audio_in cycle to the clap_detected pulse.

Reset
REQ-026 SHALL, on a clock edge with reset==0, force state=IDLE, env=0, level=0, armed=1, holdoff=0, read_audio_in=0, clap_detected=0, and clear captured samples.
REQ-027 SHALL have reset asserted mid-sequence abort the sequence with no read_audio_in or clap_detected issued in that cycle.

Configuration
REQ-028 SHALL, with macro AUDIO_DETECT_STEREO_EN defined, use mag = (magL + magR) >> 1, computed with a 17-bit sum.
REQ-029 SHALL, without AUDIO_DETECT_STEREO_EN, use mag = magL; right_channel_audio_in is ignored; handshake is unchanged.

Verification
REQ-030 SHALL cover: reset low 2 cycles, then high with available=0 -> all outputs 0, level=0, no read strobes.
REQ-031 SHALL cover: available held 1, silent input 0 -> read_audio_in pulses once every 5 clocks, clap_detected stays 0, level stays 0.
REQ-032 SHALL cover: one sample L=R=32'h1000_0000 -> level=16'h2000 and a clap_detected pulse 4 clocks after its read strobe.
REQ-033 SHALL cover: second loud sample 1000 clocks after a detection -> no pulse; after HOLDOFF_CYCLES plus a quiet re-arm -> pulse.
REQ-034 SHALL cover: sample L=32'h8000_0000 -> saturated magnitude 16'hFFFF, no wrap, pulse issued.
REQ-035 SHALL cover: stereo L=32'h1000_0000, R=0 -> level=16'h1000 with AUDIO_DETECT_STEREO_EN defined, 16'h2000 without it.

Source files
------------

// File: rtl/audio_in_detector.sv
// audio_in_detector: pops sample pairs from the Audio_Controller, tracks a
// peak-hold envelope with exponential decay, and emits a single-cycle
// clap_detected pulse when the envelope crosses THRESHOLD. Detections are
// separated by a holdoff window and re-armed by hysteresis at THRESHOLD/2.
// Optional macro AUDIO_DETECT_STEREO_EN: average left and right magnitudes
// instead of using the left channel only.
module audio_in_detector #(
    parameter logic [15:0] THRESHOLD      = 16'h0800,
    parameter int unsigned HOLDOFF_CYCLES = 25_000_000,
    parameter int unsigned DECAY_SHIFT    = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        clap_detected,
    output logic [15:0] level
);

    typedef enum logic [2:0] {IDLE, READ, MAG, ENV, CMP} state_t;

    localparam logic [31:0] HOLDOFF_LOAD = (HOLDOFF_CYCLES == 0) ? 32'd0 : 32'(HOLDOFF_CYCLES - 1);
    localparam logic [15:0] REARM_LEVEL  = THRESHOLD >> 1;

    state_t      state_q, state_d;
    logic [31:0] left_q, left_d;
    logic [15:0] mag_q, mag_d;
    logic [15:0] env_q, env_d;
    logic [15:0] env_decayed;
    logic [31:0] holdoff_q, holdoff_d;
    logic        armed_q, armed_d;
    logic        clap_q, clap_d;
    logic        seq_en_q, seq_en_d;
    logic [15:0] mag_left;
    logic [15:0] mag_sel;

    // abs(sample) saturated to 31 bits, then the top 16 magnitude bits
    function automatic logic [15:0] chan_mag(input logic [31:0] s);
        logic [31:0] a;
        if (s == 32'h8000_0000)
            a = 32'h7FFF_FFFF;
        else if (s[31])
            a = 32'd0 - s;
        else
            a = s;
        return a[30:15];
    endfunction

    assign mag_left    = chan_mag(left_q);
    assign env_decayed = env_q - (env_q >> DECAY_SHIFT);

`ifdef AUDIO_DETECT_STEREO_EN
    logic [31:0] right_q, right_d;
    logic [15:0] mag_right;
    logic [16:0] mag_sum;

    assign mag_right = chan_mag(right_q);
    assign mag_sum   = {1'b0, mag_left} + {1'b0, mag_right};
    assign mag_sel   = mag_sum[16:1];

    // right-channel capture register, loaded with the left one in READ
    always_comb begin
        right_d = right_q;
        if (state_q == READ)
            right_d = right_channel_audio_in;
    end

    // right-channel sample register
    always_ff @(posedge CLOCK_50) begin
        if (!reset)
            right_q <= '0;
        else
            right_q <= right_d;
    end
`else
    logic unused_right;

    assign unused_right = ^right_channel_audio_in;
    assign mag_sel      = mag_left;
`endif

    // The strobe is gated by reset so an aborting reset never pops a sample
    assign read_audio_in = (state_q == READ) && reset;
    assign clap_detected = clap_q;
    assign level         = env_q;

    // next-state, datapath and detection decisions
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        mag_d     = mag_q;
        env_d     = env_q;
        armed_d   = armed_q;
        clap_d    = 1'b0;
        seq_en_d  = seq_en_q;
        holdoff_d = (holdoff_q != 32'd0) ? holdoff_q - 32'd1 : 32'd0;

        case (state_q)
            IDLE: begin
                if (audio_in_available && enable) begin
                    state_d  = READ;
                    seq_en_d = 1'b1;
                end
            end
            READ: begin
                left_d  = left_channel_audio_in;
                state_d = MAG;
                if (!enable) seq_en_d = 1'b0;
            end
            MAG: begin
                mag_d   = mag_sel;
                state_d = ENV;
                if (!enable) seq_en_d = 1'b0;
            end
            ENV: begin
                env_d   = (mag_q > env_decayed) ? mag_q : env_decayed;
                state_d = CMP;
                if (!enable) seq_en_d = 1'b0;
            end
            CMP: begin
                state_d = IDLE;
                // Detection wins over re-arm when both hold
                if (armed_q && (holdoff_q == 32'd0) && (env_q >= THRESHOLD)
                        && seq_en_q && enable) begin
                    clap_d    = 1'b1;
                    armed_d   = 1'b0;
                    holdoff_d = HOLDOFF_LOAD;
                end else if ((env_q < REARM_LEVEL) && (holdoff_q == 32'd0)) begin
                    armed_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q   <= IDLE;
            left_q    <= '0;
            mag_q     <= '0;
            env_q     <= '0;
            armed_q   <= 1'b1;
            clap_q    <= 1'b0;
            seq_en_q  <= 1'b0;
            holdoff_q <= '0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            mag_q     <= mag_d;
            env_q     <= env_d;
            armed_q   <= armed_d;
            clap_q    <= clap_d;
            seq_en_q  <= seq_en_d;
            holdoff_q <= holdoff_d;
        end
    end

endmodule
